// File: rtl/sin_pkg.sv
// Shared definitions for the sine measurement block.
// Holds sample width, midscale code, crossing-counter width and the
// measurement FSM state encoding used by sin_meas and its sub-modules.
package sin_pkg;

    localparam int SAMPLE_W = 14;
    localparam int CNT_W    = 16;

    localparam logic [SAMPLE_W-1:0] MIDSCALE = 14'd8192;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } state_e;

endpackage

// File: rtl/sin_meas_if.sv
// Bus bundle for sin_meas.
// master : the consumer side, drives en/start/samples/ack, reads results.
// slave  : the measurement block itself.
// Signals:
//   en, start          block enable, one-cycle measurement request
//   adc_in, adc_valid  offset-binary sample and its qualifier
//   meas_busy          high while arming or measuring
//   meas_valid         results valid, held until meas_ack
//   cross_cnt          rising midscale crossings within the gate
//   peak_max/peak_min  extreme samples since arming, amp_pp their difference
//   no_signal          arming timed out without a crossing
interface sin_meas_if;
    import sin_pkg::*;

    logic                en;
    logic                start;
    logic [SAMPLE_W-1:0] adc_in;
    logic                adc_valid;
    logic                meas_ack;

    logic                meas_busy;
    logic                meas_valid;
    logic [CNT_W-1:0]    cross_cnt;
    logic [SAMPLE_W-1:0] peak_max;
    logic [SAMPLE_W-1:0] peak_min;
    logic [SAMPLE_W-1:0] amp_pp;
    logic                no_signal;

    modport master (
        output en, start, adc_in, adc_valid, meas_ack,
        input  meas_busy, meas_valid, cross_cnt, peak_max, peak_min, amp_pp, no_signal
    );

    modport slave (
        input  en, start, adc_in, adc_valid, meas_ack,
        output meas_busy, meas_valid, cross_cnt, peak_max, peak_min, amp_pp, no_signal
    );

endinterface

// File: rtl/sin_cross_det.sv
// Hysteresis comparator around midscale.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         re-initialise: comparator LO, next valid sample is "first"
//   sample      offset-binary sample
//   valid       sample qualifier; state only moves on valid cycles
//   hyst        hysteresis half-width in LSB
//   rise        combinational pulse in the cycle of a counted LO->HI edge,
//               so the caller sees the crossing together with its sample
module sin_cross_det
    import sin_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                valid,
    input  logic [SAMPLE_W-1:0] hyst,
    output logic                rise
);

    logic              hi_q;
    logic              first_q;
    logic [SAMPLE_W:0] thr_hi;
    logic [SAMPLE_W:0] thr_lo;
    logic              above;
    logic              below;

    // One extra bit keeps MIDSCALE+hyst from wrapping.
    assign thr_hi = {1'b0, MIDSCALE} + {1'b0, hyst};
    assign thr_lo = {1'b0, MIDSCALE} - {1'b0, hyst};
    assign above  = {1'b0, sample} >= thr_hi;
    assign below  = {1'b0, sample} <= thr_lo;

    // A first sample already above threshold only sets HI; it is not an edge.
    assign rise = valid && !clr && !hi_q && !first_q && above;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= 1'b0;
            first_q <= 1'b0;
        end else if (clr) begin
            hi_q    <= 1'b0;
            first_q <= 1'b1;
        end else if (valid) begin
            first_q <= 1'b0;
            if (!hi_q && above) begin
                hi_q <= 1'b1;
            end else if (hi_q && below) begin
                hi_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sin_meas.sv
// Sine measurement block: arms on start, waits for the first rising midscale
// crossing, then counts rising crossings over GATE_LEN valid samples while
// tracking peak values. Results are latched on entry to DONE and held with
// meas_valid until acknowledged or a new measurement is started.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sin_meas_if.slave (control, samples, handshake, results)
// Parameters:
//   GATE_LEN    valid samples per gate (also the arming timeout)
//   HYST        comparator hysteresis half-width in LSB
module sin_meas
    import sin_pkg::*;
#(
    parameter int GATE_LEN = 524288,
    parameter int HYST     = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    sin_meas_if.slave bus
);

    localparam int GATE_W = $clog2(GATE_LEN + 1);

    state_e              state_q;
    logic [GATE_W-1:0]   gate_q;
    logic [GATE_W-1:0]   gate_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [SAMPLE_W-1:0] wmax_q;
    logic [SAMPLE_W-1:0] wmax_d;
    logic [SAMPLE_W-1:0] wmin_q;
    logic [SAMPLE_W-1:0] wmin_d;
    logic                gate_done;

    logic [CNT_W-1:0]    cross_cnt_q;
    logic [SAMPLE_W-1:0] peak_max_q;
    logic [SAMPLE_W-1:0] peak_min_q;
    logic [SAMPLE_W-1:0] amp_pp_q;
    logic                no_signal_q;
    logic                meas_valid_q;
    logic                meas_busy_q;

    logic                sample_en;
    logic                arm_req;
    logic                rise;

    assign sample_en = bus.en && bus.adc_valid && (state_q == ARM || state_q == MEASURE);
    assign arm_req   = bus.en && bus.start && (state_q == IDLE || state_q == DONE);

    sin_cross_det u_cross (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (arm_req),
        .sample (bus.adc_in),
        .valid  (sample_en),
        .hyst   (SAMPLE_W'(HYST)),
        .rise   (rise)
    );

    // NOTE: every always_comb output is assigned unconditionally, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        gate_d    = gate_q + GATE_W'(1);
        gate_done = (gate_d == GATE_W'(GATE_LEN));
        cnt_d     = (rise && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        wmax_d    = (bus.adc_in > wmax_q) ? bus.adc_in : wmax_q;
        wmin_d    = (bus.adc_in < wmin_q) ? bus.adc_in : wmin_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gate_q       <= '0;
            cnt_q        <= '0;
            wmax_q       <= '0;
            wmin_q       <= '0;
            cross_cnt_q  <= '0;
            peak_max_q   <= '0;
            peak_min_q   <= '0;
            amp_pp_q     <= '0;
            no_signal_q  <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_busy_q  <= 1'b0;
        end else if (!bus.en) begin
            // Abort: result registers keep their last values.
            state_q      <= IDLE;
            meas_valid_q <= 1'b0;
            meas_busy_q  <= 1'b0;
        end else if (arm_req) begin
            state_q      <= ARM;
            gate_q       <= '0;
            cnt_q        <= '0;
            wmax_q       <= '0;
            wmin_q       <= '1;
            meas_valid_q <= 1'b0;
            meas_busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ARM: if (bus.adc_valid) begin
                    wmax_q <= wmax_d;
                    wmin_q <= wmin_d;
                    if (rise) begin
                        // The arming crossing opens the gate but is not counted.
                        state_q <= MEASURE;
                        gate_q  <= '0;
                    end else if (gate_done) begin
                        state_q      <= DONE;
                        cross_cnt_q  <= '0;
                        peak_max_q   <= wmax_d;
                        peak_min_q   <= wmin_d;
                        amp_pp_q     <= wmax_d - wmin_d;
                        no_signal_q  <= 1'b1;
                        meas_valid_q <= 1'b1;
                        meas_busy_q  <= 1'b0;
                    end else begin
                        gate_q <= gate_d;
                    end
                end
                MEASURE: if (bus.adc_valid) begin
                    wmax_q <= wmax_d;
                    wmin_q <= wmin_d;
                    cnt_q  <= cnt_d;
                    if (gate_done) begin
                        // cnt_d includes a crossing on the closing sample.
                        state_q      <= DONE;
                        cross_cnt_q  <= cnt_d;
                        peak_max_q   <= wmax_d;
                        peak_min_q   <= wmin_d;
                        amp_pp_q     <= wmax_d - wmin_d;
                        no_signal_q  <= 1'b0;
                        meas_valid_q <= 1'b1;
                        meas_busy_q  <= 1'b0;
                    end else begin
                        gate_q <= gate_d;
                    end
                end
                DONE: if (bus.meas_ack) begin
                    state_q      <= IDLE;
                    meas_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.meas_busy  = meas_busy_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.cross_cnt  = cross_cnt_q;
    assign bus.peak_max   = peak_max_q;
    assign bus.peak_min   = peak_min_q;
    assign bus.amp_pp     = amp_pp_q;
    assign bus.no_signal  = no_signal_q;

endmodule

// File: doc/sin_meas.md
SIN_MEAS -- requirements
Module: sin_meas

Interface
REQ-001 SHALL have parameter GATE_LEN, default 524288, the number of valid samples in the measurement gate; at this default cross_cnt numerically equals the generator's state_freq.
REQ-002 SHALL have parameter HYST, default 64, the hysteresis half-width in LSB around midscale 8192.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  in  1  rising-edge clock for all state.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: en  in  1  block enable; low aborts any measurement and forces IDLE.
REQ-007 Port: start  in  1  one-cycle request to begin a measurement.
REQ-008 Port: adc_in  in  14  offset-binary sample, midscale 8192.
REQ-009 Port: adc_valid  in  1  adc_in is valid this cycle.
REQ-010 Port: meas_busy  out  1  high in ARM or MEASURE.
REQ-011 Port: meas_valid  out  1  results valid; held until acknowledged.
REQ-012 Port: meas_ack  in  1  consumer acknowledge of results.
REQ-013 Port: cross_cnt  out  16  rising midscale crossings within the gate; saturates at 65535.
REQ-014 Port: peak_max / peak_min  out  14 each  largest / smallest sample seen since ARM entry.
REQ-015 Port: amp_pp  out  14  peak_max minus peak_min.
REQ-016 Port: no_signal  out  1  the ARM state timed out without a crossing.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, MEASURE, DONE.
REQ-018 IDLE->ARM on start && en; on ARM entry, clear the crossing count and gate count, set peak_max=0 and peak_min=16383.
REQ-019 Only cycles with adc_valid=1 SHALL update the comparator, counters or peaks; other cycles hold all state.
REQ-020 Comparator state SHALL go LO->HI when adc_in >= 8192+HYST and HI->LO when adc_in <= 8192-HYST; a rising crossing is a LO->HI transition.
REQ-021 The comparator SHALL initialise to LO when entering ARM, and SHALL set HI without counting a crossing if the first valid sample is >= 8192+HYST.
REQ-022 ARM->MEASURE on the first rising crossing; that crossing is not counted.
REQ-023 ARM->DONE with cross_cnt=0 and no_signal=1 after GATE_LEN valid samples without a crossing.
REQ-024 MEASURE SHALL count GATE_LEN valid samples, incrementing the crossing count on each rising crossing, then go to DONE; the sample that completes the gate SHALL still be evaluated for a crossing.
REQ-025 Peaks SHALL update on every valid sample in ARM and MEASURE.
REQ-026 On DONE entry, register cross_cnt, peak_max, peak_min, amp_pp and no_signal, and raise meas_valid one cycle after the final gate sample.
REQ-027 Result outputs SHALL hold stable while meas_valid=1.
REQ-028 DONE->IDLE on meas_ack, clearing meas_valid the next cycle.
REQ-029 DONE with start=1 (with or without meas_ack) SHALL go to ARM and clear meas_valid.
REQ-030 start SHALL be ignored in ARM and MEASURE; meas_ack SHALL be ignored outside DONE.
REQ-031 en=0 SHALL force IDLE synchronously and clear meas_valid and meas_busy; result registers keep their last values.
REQ-032 The gate counter SHALL be ceil(log2(GATE_LEN+1)) bits wide; the crossing counter SHALL saturate rather than wrap.

Reset
REQ-033 Reset SHALL force state IDLE, meas_busy=0, meas_valid=0, no_signal=0, cross_cnt=0, peak_max=0, peak_min=0, amp_pp=0, comparator LO and counters 0.
REQ-034 Reset asserted mid-measurement SHALL discard the measurement with no result presented.

Structure
REQ-035 Shared package sin_pkg SHALL hold MIDSCALE=8192, SAMPLE_W=14, and the FSM state enumeration.
REQ-036 The comparator SHALL be sub-module sin_cross_det (inputs clk, rst_n, clr, sample, valid, hyst; output one-cycle rise pulse).

Verification
REQ-037 Reset: assert rst_n=0 mid-MEASURE -> all outputs 0, state IDLE, no meas_valid afterwards.
REQ-038 GATE_LEN=1024, sine period 64 samples, 8192±4000, adc_valid=1 -> cross_cnt=16, peak_max=12192, peak_min=4192, amp_pp=8000, no_signal=0.
REQ-039 Same stimulus as REQ-038 with adc_valid toggling every cycle -> identical results, meas_valid about 2x later.
REQ-040 GATE_LEN=1024, HYST=64, constant 8192 ±40 noise -> after 1024 valid samples: DONE, cross_cnt=0, no_signal=1, amp_pp<=80.
REQ-041 Handshake: meas_valid held ≥10 cycles with no ack, outputs stable; meas_ack -> meas_valid=0 next cycle; start in DONE -> ARM and meas_busy=1.
REQ-042 en dropped mid-MEASURE -> IDLE next cycle, meas_busy=0, meas_valid never asserted.
